// File: rtl/param_vending_fsm.sv
// rtl/param_vending_fsm.sv - parametrised vending controller: credit, per-item stock, dispense and change pulses
module param_vending_fsm #(
  parameter int NUM_ITEMS = 4,
  parameter int ITEM_W = 2,
  parameter int CREDIT_W = 8,
  parameter logic [CREDIT_W*NUM_ITEMS-1:0] PRICES = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           coin,
  input  logic                 sel_valid,
  input  logic [ITEM_W-1:0]    sel_item,
  input  logic                 cancel,
  input  logic                 restock,
  output logic [1:0]           state,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 vend,
  output logic [ITEM_W-1:0]    vend_item,
  output logic                 chg_pulse,
  output logic                 coin_reject,
  output logic                 sel_err,
  output logic [NUM_ITEMS-1:0] sold_out
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_CHANGE  = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]      CREDIT_MAX  = {1'b0, {CREDIT_W{1'b1}}};
  localparam logic [STOCK_W-1:0]     STOCK_RST   = STOCK_W'(STOCK_INIT);
  localparam logic [NUM_ITEMS-1:0]   SOLD_RST    = (STOCK_INIT == 0) ? '1 : '0;
  localparam logic [ITEM_W:0]        NUM_ITEMS_V = (ITEM_W + 1)'(NUM_ITEMS);

  state_t                st;
  logic [STOCK_W-1:0]    stock [NUM_ITEMS];
  logic [CREDIT_W-1:0]   price_tab [NUM_ITEMS];
  logic [CREDIT_W-1:0]   coin_val;
  logic [CREDIT_W:0]     coin_sum;
  logic                  coin_ok;
  logic                  coin_fits;
  logic                  coin_present;
  logic [CREDIT_W-1:0]   sel_price;
  logic                  sel_ok;

  assign state = st;

  always_comb begin
    for (int i = 0; i < NUM_ITEMS; i++) begin
      price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
    end
    coin_val = '0;
    case (coin)
      4'b0001: coin_val = CREDIT_W'(1);
      4'b0010: coin_val = CREDIT_W'(2);
      4'b0100: coin_val = CREDIT_W'(5);
      4'b1000: coin_val = CREDIT_W'(10);
      default: coin_val = '0;
    endcase
    coin_present = (coin != 4'b0000);
    coin_ok      = (coin_val != '0);
    coin_sum     = {1'b0, credit} + {1'b0, coin_val};
    coin_fits    = (coin_sum <= CREDIT_MAX);
    sel_price    = '0;
    sel_ok       = 1'b0;
    // Out-of-range indices (non power-of-two NUM_ITEMS) are refused outright.
    if ({1'b0, sel_item} < NUM_ITEMS_V) begin
      sel_price = price_tab[sel_item];
      sel_ok    = (stock[sel_item] != '0) && (credit >= sel_price);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      credit      <= '0;
      vend        <= 1'b0;
      vend_item   <= '0;
      chg_pulse   <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      sold_out    <= SOLD_RST;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        stock[i] <= STOCK_RST;
      end
    end else begin
      vend        <= 1'b0;
      chg_pulse   <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      case (st)
        S_IDLE: begin
          if (restock) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
              stock[i] <= STOCK_RST;
            end
            sold_out <= SOLD_RST;
          end
          if (coin_ok) begin
            credit <= coin_val;
            st     <= S_COLLECT;
          end else if (coin_present) begin
            coin_reject <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (cancel) begin
            coin_reject <= coin_present;
            st          <= S_CHANGE;
          end else if (sel_valid) begin
            coin_reject <= coin_present;
            if (!sel_ok) begin
              sel_err <= 1'b1;
            end else begin
              // Debit and dispense bookkeeping land together so vend coincides with the VEND state.
              vend                <= 1'b1;
              vend_item           <= sel_item;
              credit              <= credit - sel_price;
              stock[sel_item]     <= stock[sel_item] - 1'b1;
              sold_out[sel_item]  <= (stock[sel_item] == STOCK_W'(1));
              st                  <= S_VEND;
            end
          end else if (coin_ok && coin_fits) begin
            credit <= coin_sum[CREDIT_W-1:0];
          end else if (coin_present) begin
            coin_reject <= 1'b1;
          end
        end
        S_VEND: begin
          coin_reject <= coin_present;
          st          <= (credit != '0) ? S_CHANGE : S_IDLE;
        end
        S_CHANGE: begin
          coin_reject <= coin_present;
          if (credit != '0) begin
            chg_pulse <= 1'b1;
            credit    <= credit - 1'b1;
          end
          if (credit <= CREDIT_W'(1)) begin
            st <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule
